// File: rtl/fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb
// Two-requester write arbiter in front of a single FIFO write port.
// Ownership is granted to one requester at a time. An owner may write up to
// MAX_BURST consecutive words while the other side waits, then ownership
// passes over. Writes are zero-latency: wr_en and wr_data follow the owner's
// valid/data combinationally in the cycle the word is accepted.
//
// Parameters
//   DATA_WIDTH  width of each write word
//   MAX_BURST   consecutive accepts per grant while the other side waits (1..15)
//
// Ports
//   clk         sole clock
//   nrst        asynchronous active-low reset
//   req0_valid  requester 0 has a word
//   req0_data   requester 0 word
//   req0_ready  requester 0 word accepted this cycle when valid
//   req1_valid  requester 1 has a word
//   req1_data   requester 1 word
//   req1_ready  requester 1 word accepted this cycle when valid
//   full        FIFO write-side full flag
//   wr_en       FIFO write strobe
//   wr_data     FIFO write word (holds its last value when nothing is written)
//   grant       one-hot current owner, 00 when idle
//   busy        high whenever a requester owns the port
// -----------------------------------------------------------------------------
module fifo_wr_arb #(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  req0_valid,
   input  logic [DATA_WIDTH-1:0] req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [DATA_WIDTH-1:0] req1_data,
   output logic                  req1_ready,
   input  logic                  full,
   output logic                  wr_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic [1:0]            grant,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN0 = 2'd1,
      S_OWN1 = 2'd2
   } state_t;

   localparam logic [3:0] C_MAX_BURST = 4'(MAX_BURST);

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_last;
   logic                  w_last_next;
   logic [3:0]            r_burst_cnt;
   logic [3:0]            w_burst_cnt_next;
   logic [DATA_WIDTH-1:0] r_wr_data;
   logic [DATA_WIDTH-1:0] w_wr_data;

   logic       w_own0;
   logic       w_own1;
   logic       w_acc0;
   logic       w_acc1;
   logic       w_mine_valid;
   logic       w_other_valid;
   logic       w_other_idx;
   logic [3:0] w_cnt_inc;
   logic       w_burst_done;

   assign w_own0 = (r_state == S_OWN0);
   assign w_own1 = (r_state == S_OWN1);

   assign req0_ready = w_own0 && !full;
   assign req1_ready = w_own1 && !full;

   assign w_acc0 = req0_valid && req0_ready;
   assign w_acc1 = req1_valid && req1_ready;

   assign wr_en     = w_acc0 || w_acc1;
   assign w_wr_data = w_acc0 ? req0_data :
                      w_acc1 ? req1_data : r_wr_data;
   assign wr_data   = w_wr_data;

   assign grant = {w_own1, w_own0};
   assign busy  = (r_state != S_IDLE);

   // Owner-relative view so OWN0 and OWN1 share one set of transition rules.
   assign w_mine_valid  = w_own1 ? req1_valid : req0_valid;
   assign w_other_valid = w_own1 ? req0_valid : req1_valid;
   assign w_other_idx   = w_own0;

   assign w_cnt_inc    = r_burst_cnt + 4'd1;
   assign w_burst_done = (w_cnt_inc == C_MAX_BURST);

   always_comb begin
      w_state_next     = r_state;
      w_last_next      = r_last;
      w_burst_cnt_next = r_burst_cnt;
      case (r_state)
         S_IDLE: begin
            // With both asking, requester 0 wins only if 1 had it last.
            if (req0_valid && (!req1_valid || r_last)) begin
               w_state_next     = S_OWN0;
               w_last_next      = 1'b0;
               w_burst_cnt_next = 4'd0;
            end else if (req1_valid) begin
               w_state_next     = S_OWN1;
               w_last_next      = 1'b1;
               w_burst_cnt_next = 4'd0;
            end
         end
         S_OWN0, S_OWN1: begin
            // Full freezes everything: no accept, no handoff, no count change.
            if (!full) begin
               if (!w_mine_valid || w_burst_done) begin
                  if (w_other_valid) begin
                     w_state_next     = w_other_idx ? S_OWN1 : S_OWN0;
                     w_last_next      = w_other_idx;
                     w_burst_cnt_next = 4'd0;
                  end else begin
                     // Burst limit with nobody waiting restarts the count in
                     // place; a dropped valid with nobody waiting goes idle.
                     w_burst_cnt_next = 4'd0;
                     if (!w_mine_valid) begin
                        w_state_next = S_IDLE;
                     end
                  end
               end else begin
                  w_burst_cnt_next = w_cnt_inc;
               end
            end
         end
         default: begin
            w_state_next     = S_IDLE;
            w_burst_cnt_next = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= S_IDLE;
         r_last      <= 1'b1;
         r_burst_cnt <= 4'd0;
         r_wr_data   <= '0;
      end else begin
         r_state     <= w_state_next;
         r_last      <= w_last_next;
         r_burst_cnt <= w_burst_cnt_next;
         r_wr_data   <= w_wr_data;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb
// Directed scenarios followed by randomized traffic. Each cycle the bench
// drives requester/full inputs at the falling edge, compares every output
// against a cycle-level reference model of the arbitration rules, then
// advances the model. Requesters keep valid/data steady until accepted.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb;

   localparam int DW = 8;
   localparam int MB = 4;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic          req0_valid = 1'b0;
   logic [DW-1:0] req0_data = '0;
   logic          req0_ready;
   logic          req1_valid = 1'b0;
   logic [DW-1:0] req1_data = '0;
   logic          req1_ready;
   logic          full = 1'b0;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic [1:0]    grant;
   logic          busy;

   fifo_wr_arb #(.DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .full       (full),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .grant      (grant),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Requester side: a pending word must be held until accepted.
   bit   [1:0]    pend;
   logic [DW-1:0] next_word [2];
   int            dut_wr_cnt;

   // Reference model: owner index (-1 = nobody), last winner, writes in burst.
   int            m_owner;
   int            m_last;
   int            m_streak;
   logic [DW-1:0] m_wr_data;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_last    = 1;
      m_streak  = 0;
      m_wr_data = '0;
   endtask

   task automatic model_give(input int n);
      m_owner  = n;
      m_last   = n;
      m_streak = 0;
   endtask

   // One clock cycle: drive, compare against model, advance model.
   task automatic cycle(input bit want0, input bit want1, input bit f);
      bit   [1:0]    vld;
      logic [DW-1:0] dat [2];
      bit            acc;
      logic [1:0]    exp_grant;
      int            oth;
      @(negedge clk);
      vld[0] = pend[0] | want0;
      vld[1] = pend[1] | want1;
      dat[0] = next_word[0];
      dat[1] = next_word[1];
      req0_valid = vld[0];
      req1_valid = vld[1];
      req0_data  = dat[0];
      req1_data  = dat[1];
      full       = f;
      #1;
      acc = 1'b0;
      exp_grant = 2'b00;
      if (m_owner >= 0) begin
         acc = !f && vld[m_owner];
         exp_grant = (m_owner == 0) ? 2'b01 : 2'b10;
      end
      if (acc) m_wr_data = dat[m_owner];
      check("grant", grant, exp_grant);
      check("busy", busy, m_owner >= 0);
      check("ready0", req0_ready, (m_owner == 0) && !f);
      check("ready1", req1_ready, (m_owner == 1) && !f);
      check("wr_en", wr_en, acc);
      check("wr_data", wr_data, m_wr_data);
      if (wr_en === 1'b1) dut_wr_cnt++;
      $display("[TB] t=%0t v=%b%b full=%b grant=%b wr_en=%b wr_data=%h",
               $time, vld[1], vld[0], f, grant, wr_en, wr_data);
      // Requester bookkeeping
      for (int n = 0; n < 2; n++) begin
         pend[n] = vld[n] && !(acc && m_owner == n);
         if (acc && m_owner == n) next_word[n] = next_word[n] + 8'd1;
      end
      // Next-owner rules
      if (m_owner < 0) begin
         if (vld[0] && vld[1]) model_give(1 - m_last);
         else if (vld[0])      model_give(0);
         else if (vld[1])      model_give(1);
      end else if (!f) begin
         oth = 1 - m_owner;
         if (acc) begin
            m_streak++;
            if (m_streak == MB) begin
               if (vld[oth]) model_give(oth);
               else          m_streak = 0;
            end
         end else if (vld[oth]) begin
            model_give(oth);
         end else begin
            m_owner = -1;
         end
      end
   endtask

   // Assert reset away from any clock edge, check outputs clear at once.
   task automatic reset_pulse();
      @(negedge clk);
      #2;
      nrst = 1'b0;
      #1;
      check("rst_wr_en", wr_en, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_wr_data", wr_data, 0);
      model_reset();
      pend       = 2'b00;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      full       = 1'b0;
      @(posedge clk);
      #1;
      check("rst_grant_hold", grant, 0);
      @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      model_reset();
      pend         = 2'b00;
      next_word[0] = 8'h11;
      next_word[1] = 8'h21;
      dut_wr_cnt   = 0;
      reset_pulse();

      // Single requester: six back-to-back words, no handoff.
      dut_wr_cnt = 0;
      repeat (7) cycle(1'b1, 1'b0, 1'b0);
      check("req0_only_writes", dut_wr_cnt, 6);
      check("req0_only_last_word", wr_data, 8'h16);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);

      // Both requesters continuously: alternating bursts of MB.
      reset_pulse();
      dut_wr_cnt = 0;
      repeat (25) cycle(1'b1, 1'b1, 1'b0);
      check("both_writes", dut_wr_cnt, 24);

      // Owner 1 stalled by full for five cycles mid-burst.
      reset_pulse();
      repeat (3) cycle(1'b0, 1'b1, 1'b0);
      dut_wr_cnt = 0;
      repeat (5) cycle(1'b1, 1'b1, 1'b1);
      check("full_no_writes", dut_wr_cnt, 0);
      check("full_grant", grant, 2'b10);
      repeat (2) cycle(1'b1, 1'b1, 1'b0);
      check("after_full_writes", dut_wr_cnt, 2);
      cycle(1'b1, 1'b1, 1'b0);
      check("after_full_handoff", grant, 2'b01);

      // Owner 0 drops after one write; next tie goes to requester 1.
      reset_pulse();
      repeat (2) cycle(1'b1, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0);
      check("drop_idle_busy", busy, 0);
      repeat (2) cycle(1'b1, 1'b1, 1'b0);
      check("tie_after_req0", grant, 2'b10);

      // Reset mid-burst in OWN1; first grant afterwards is requester 0.
      reset_pulse();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      check("own1_before_rst", grant, 2'b10);
      reset_pulse();
      repeat (2) cycle(1'b1, 1'b1, 1'b0);
      check("first_grant_after_rst", grant, 2'b01);

      // Randomized traffic with random backpressure.
      reset_pulse();
      repeat (3000) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
